spm_seq: RTL and testbench

Sequencer placed around the serial-parallel multiplier (`spm`). It accepts a parallel operand pair (x, y) over a valid/ready handshake and pulses the multiplier's reset. It then shifts y into the multiplier LSB-first, one bit per clock, and collects the serial product bits `p` into a 2N-bit word. The word is presented on a valid/ready output port. It replaces hand-sequenced testbench stimulus with a reusable upstream/downstream stage.

---
 rtl/spm_seq_pkg.sv | 16 +
 rtl/spm.sv | 28 ++
 rtl/spm_seq_shift.sv | 31 +++
 rtl/spm_seq.sv | 143 ++++++++++++++
 tb/tb_spm_seq.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/spm_seq_pkg.sv
// Shared types and helpers for the spm_seq sequencer around the serial-parallel multiplier.
package spm_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // The counter must hold 2N+P_LAT, the value reached on the last RUN edge.
    function automatic int cnt_w(input int n, input int p_lat);
        return $clog2(2 * n + p_lat + 1);
    endfunction

endpackage

// File: rtl/spm.sv
// Unsigned serial-parallel multiplier: y enters LSB-first, product bits leave on p with no latency.
module spm #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] x,
    input  logic         y,
    output logic         p
);

    logic [N-1:0] acc_r;
    logic [N:0]   sum_s;

    // The accumulator never exceeds x, so N bits hold the carried partial sum.
    assign sum_s = {1'b0, acc_r} + ({1'b0, x} & {(N + 1){y}});
    assign p     = sum_s[0];

    // Keep the upper part of the partial sum for the next bit position.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
        end else begin
            acc_r <= sum_s[N:1];
        end
    end

endmodule

// File: rtl/spm_seq_shift.sv
// Right shift register with parallel load, shift enable and MSB serial input.
module spm_seq_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift_en,
    input  logic         sin,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Load has priority over shift; the register holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= '0;
        end else if (load) begin
            q_r <= load_val;
        end else if (shift_en) begin
            q_r <= {sin, q_r[W-1:1]};
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/spm_seq.sv
// Sequencer that feeds an external spm with one operand pair at a time and
// collects the serial product into a 2N-bit word behind valid/ready ports.
module spm_seq
    import spm_seq_pkg::*;
#(
    parameter int N     = 8,
    parameter int P_LAT = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_x,
    input  logic [N-1:0]   in_y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_p,
    output logic           spm_rst,
    output logic [N-1:0]   spm_x,
    output logic           spm_y,
    input  logic           spm_p
);

    localparam int            CW       = cnt_w(N, P_LAT);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * N + P_LAT - 1);

    state_t          state_r;
    state_t          state_nx_s;
    logic [CW-1:0]   cnt_r;
    logic [N-1:0]    x_r;
    logic [N-1:0]    y_q_s;
    logic [2*N-1:0]  p_q_s;
    logic            accept_s;
    logic            run_s;
    logic            p_gate_s;
    logic            unused_y_s;

    // Next-state decode and acceptance strobe.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    accept_s   = 1'b1;
                    state_nx_s = CLR;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CLR: state_nx_s = RUN;
            RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    assign run_s = (state_r == RUN);

    // Bit counter: cleared in CLR so RUN always starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (state_r == CLR) begin
            cnt_r <= '0;
        end else if (run_s) begin
            cnt_r <= cnt_r + {{(CW - 1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Multiplicand register, stable from acceptance to the next acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r <= '0;
        end else if (accept_s) begin
            x_r <= in_x;
        end else begin
            x_r <= x_r;
        end
    end

    // Product bits only become meaningful once the spm latency has elapsed.
    generate
        if (P_LAT == 0) begin : g_no_lat
            assign p_gate_s = 1'b1;
        end else begin : g_lat
            assign p_gate_s = (cnt_r >= CW'(P_LAT));
        end
    endgenerate

    spm_seq_shift #(.W(N)) u_y_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .load_val (in_y),
        .shift_en (run_s),
        .sin      (1'b0),
        .q        (y_q_s)
    );

    spm_seq_shift #(.W(2 * N)) u_p_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .load_val ({(2 * N){1'b0}}),
        .shift_en (run_s & p_gate_s),
        .sin      (spm_p),
        .q        (p_q_s)
    );

    assign unused_y_s = ^y_q_s[N-1:1];

    assign in_ready  = (state_r == IDLE) & ~rst;
    assign out_valid = (state_r == DONE) & ~rst;
    assign out_p     = p_q_s;
    assign spm_rst   = rst | (state_r == CLR);
    assign spm_x     = x_r;
    assign spm_y     = run_s & y_q_s[0];

endmodule

// File: tb/tb_spm_seq.sv
// Directed self-checking bench for spm_seq driving an spm #(8).
module tb_spm_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_x;
    logic [7:0]  in_y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic        spm_rst;
    logic [7:0]  spm_x;
    logic        spm_y;
    logic        spm_p;

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    spm_seq #(.N(8), .P_LAT(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .spm_rst   (spm_rst),
        .spm_x     (spm_x),
        .spm_y     (spm_y),
        .spm_p     (spm_p)
    );

    spm #(.N(8)) u_spm (
        .clk (clk),
        .rst (spm_rst),
        .x   (spm_x),
        .y   (spm_y),
        .p   (spm_p)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int start, input int limit, output int cyc);
        cyc = start;
        while (out_valid !== 1'b1 && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    // Accept one pair with out_ready high and check latency, product and release.
    task automatic run_txn(input logic [7:0] x, input logic [7:0] y,
                           input logic [15:0] exp, input string tag);
        int c;
        out_ready = 1'b1;
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_rst0"}, {31'd0, spm_rst}, 32'd0);
        in_x = x; in_y = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_clr"}, {31'd0, spm_rst}, 32'd1);
        tick();
        chk({tag, "_clr_end"}, {31'd0, spm_rst}, 32'd0);
        wait_valid(2, 40, c);
        chk({tag, "_lat"}, c, 32'd18);
        chk({tag, "_p"}, {16'd0, out_p}, {16'd0, exp});
        tick();
        chk({tag, "_vdrop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_rdy_after"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int c;
        int a0;
        int a1;
        int seen;

        rst = 1'b1; in_valid = 1'b0; in_x = 8'd0; in_y = 8'd0; out_ready = 1'b0;
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_spm_rst", {31'd0, spm_rst}, 32'd1);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_p", {16'd0, out_p}, 32'd0);
        chk("post_rst_x", {24'd0, spm_x}, 32'd0);

        run_txn(8'd50, 8'd206, 16'h283C, "basic");
        run_txn(8'd0, 8'd255, 16'h0000, "zero");
        run_txn(8'd127, 8'd255, 16'h7E81, "max");

        // Backpressure: 13*11 = 143 held for 10 cycles.
        out_ready = 1'b0;
        in_x = 8'd13; in_y = 8'd11; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(1, 40, c);
        chk("bp_lat", c, 32'd18);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_p", {16'd0, out_p}, 32'd143);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            if (i < 9) tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back with in_valid held high.
        in_x = 8'd3; in_y = 8'd5; in_valid = 1'b1;
        a0 = cyc_n;
        tick();
        in_x = 8'd9; in_y = 8'd7;
        wait_valid(1, 40, c);
        chk("b2b_p0", {16'd0, out_p}, 32'd15);
        tick();
        chk("b2b_ready", {31'd0, in_ready}, 32'd1);
        a1 = cyc_n;
        tick();
        in_valid = 1'b0;
        chk("b2b_interval", a1 - a0, 32'd19);
        chk("b2b_x", {24'd0, spm_x}, 32'd9);
        wait_valid(1, 40, c);
        chk("b2b_lat1", c, 32'd18);
        chk("b2b_p1", {16'd0, out_p}, 32'd63);
        tick();

        // Reset six cycles into RUN drops the transaction.
        in_x = 8'd6; in_y = 8'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_spm_rst", {31'd0, spm_rst}, 32'd1);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_idle", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid === 1'b1) seen++;
            tick();
        end
        chk("mid_rst_no_out", seen, 32'd0);
        run_txn(8'd2, 8'd2, 16'd4, "after_rst");

        // Operand changes and in_valid toggling during RUN are ignored.
        in_x = 8'd10; in_y = 8'd12; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            in_x = 8'(8'd100 + 8'(i));
            in_y = 8'(8'd200 - 8'(i));
            tick();
            if (spm_x !== 8'd10) seen++;
        end
        chk("ign_spm_x", seen, 32'd0);
        in_valid = 1'b0;
        wait_valid(12, 40, c);
        chk("ign_lat", c, 32'd18);
        chk("ign_p", {16'd0, out_p}, 32'd120);
        tick();
        chk("ign_idle", {31'd0, in_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
